// File: rtl/uart_ctrl.sv
// Memory-mapped UART: CTRL/STATUS/BAUD registers, TX and RX FIFOs, 8N1 framing.
// Register reads are combinational and side-effect free; writes land on the clock edge.
module uart_ctrl #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] BAUD_RST = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    input  logic        we_i,
    output logic        tx_pin,
    input  logic        rx_pin
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [2:0]  sel;
    logic        wr_ctrl, wr_status, wr_baud, wr_txdata, wr_rxpop;
    logic        tx_en, rx_en, rx_overrun, frame_err;
    logic [15:0] baud;
    logic        unused_bits;

    assign sel       = addr_i[4:2];
    assign wr_ctrl   = we_i && (sel == 3'd0);
    assign wr_status = we_i && (sel == 3'd1);
    assign wr_baud   = we_i && (sel == 3'd2);
    assign wr_txdata = we_i && (sel == 3'd3);
    assign wr_rxpop  = we_i && (sel == 3'd5);
    assign unused_bits = &{1'b0, addr_i[31:5], addr_i[1:0], data_i[31:16]};

    // ---------------- TX FIFO ----------------
    logic [7:0]  tx_mem [DEPTH];
    logic [AW:0] tx_wptr, tx_rptr;
    logic        tx_empty, tx_full, tx_push, tx_pop;

    assign tx_empty = (tx_wptr == tx_rptr);
    assign tx_full  = (tx_wptr[AW] != tx_rptr[AW]) && (tx_wptr[AW-1:0] == tx_rptr[AW-1:0]);
    assign tx_push  = wr_txdata && (!tx_full || tx_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + PTR_ONE;
            if (tx_pop)  tx_rptr <= tx_rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr[AW-1:0]] <= data_i[7:0];
    end

    // ---------------- TX FSM ----------------
    state_t      tx_state, tx_next;
    logic [15:0] tx_cnt, tx_baud;
    logic [7:0]  tx_shift;
    logic [2:0]  tx_idx;
    logic        tx_bit_end, tx_load;

    assign tx_bit_end = (tx_cnt == tx_baud - 16'd1);
    assign tx_pop     = tx_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_state <= IDLE;
        else     tx_state <= tx_next;
    end

    // STOP chains straight into START so queued bytes go out with no idle gap.
    always_comb begin
        tx_next = tx_state;
        tx_load = 1'b0;
        case (tx_state)
            IDLE: if (tx_en && !tx_empty) begin
                tx_next = START;
                tx_load = 1'b1;
            end
            START: if (tx_bit_end) tx_next = DATA;
            DATA:  if (tx_bit_end && (tx_idx == 3'd7)) tx_next = STOP;
            STOP: if (tx_bit_end) begin
                if (tx_en && !tx_empty) begin
                    tx_next = START;
                    tx_load = 1'b1;
                end else begin
                    tx_next = IDLE;
                end
            end
            default: tx_next = IDLE;
        endcase
    end

    always_comb begin
        tx_pin = 1'b1;
        case (tx_state)
            START:   tx_pin = 1'b0;
            DATA:    tx_pin = tx_shift[tx_idx];
            default: tx_pin = 1'b1;
        endcase
    end

    // The divider is re-latched at every bit boundary so BAUD changes never split a bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_cnt   <= '0;
            tx_baud  <= BAUD_RST;
            tx_shift <= '0;
            tx_idx   <= '0;
        end else if (tx_load) begin
            tx_cnt   <= '0;
            tx_baud  <= baud;
            tx_shift <= tx_mem[tx_rptr[AW-1:0]];
            tx_idx   <= '0;
        end else if (tx_state != IDLE) begin
            if (tx_bit_end) begin
                tx_cnt  <= '0;
                tx_baud <= baud;
                if (tx_state == DATA) tx_idx <= tx_idx + 3'd1;
            end else begin
                tx_cnt <= tx_cnt + 16'd1;
            end
        end
    end

    // ---------------- RX front end and FSM ----------------
    logic        rx_sync1, rx_sync2, rx_prev, rx_fall;
    state_t      rx_state, rx_next;
    logic [15:0] rx_cnt, rx_baud;
    logic [7:0]  rx_shift;
    logic [2:0]  rx_idx;
    logic        rx_bit_end, rx_half_end, rx_sample, rx_done, rx_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync1 <= 1'b1;
            rx_sync2 <= 1'b1;
            rx_prev  <= 1'b1;
        end else begin
            rx_sync1 <= rx_pin;
            rx_sync2 <= rx_sync1;
            rx_prev  <= rx_sync2;
        end
    end

    assign rx_fall     = rx_prev & ~rx_sync2;
    assign rx_bit_end  = (rx_cnt == rx_baud - 16'd1);
    assign rx_half_end = (rx_cnt == (rx_baud >> 1) - 16'd1);
    assign rx_sample   = (rx_state == START) ? rx_half_end : rx_bit_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_state <= IDLE;
        else     rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            IDLE:  if (rx_fall) rx_next = START;
            START: if (rx_half_end) rx_next = rx_sync2 ? IDLE : DATA;
            DATA:  if (rx_bit_end && (rx_idx == 3'd7)) rx_next = STOP;
            STOP:  if (rx_bit_end) rx_next = IDLE;
            default: rx_next = IDLE;
        endcase
        if (!rx_en) rx_next = IDLE;
    end

    always_comb begin
        rx_done = 1'b0;
        rx_bad  = 1'b0;
        if (rx_en && (rx_state == STOP) && rx_bit_end) begin
            rx_done = rx_sync2;
            rx_bad  = ~rx_sync2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_cnt   <= '0;
            rx_baud  <= BAUD_RST;
            rx_shift <= '0;
            rx_idx   <= '0;
        end else if (!rx_en || (rx_state == IDLE)) begin
            rx_cnt  <= '0;
            rx_idx  <= '0;
            rx_baud <= baud;
        end else if (rx_sample) begin
            rx_cnt  <= '0;
            rx_baud <= baud;
            if (rx_state == DATA) begin
                rx_shift <= {rx_sync2, rx_shift[7:1]};
                rx_idx   <= rx_idx + 3'd1;
            end
        end else begin
            rx_cnt <= rx_cnt + 16'd1;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]  rx_mem [DEPTH];
    logic [AW:0] rx_wptr, rx_rptr;
    logic        rx_empty, rx_full, rx_push, rx_pop, overrun_set;

    assign rx_empty    = (rx_wptr == rx_rptr);
    assign rx_full     = (rx_wptr[AW] != rx_rptr[AW]) && (rx_wptr[AW-1:0] == rx_rptr[AW-1:0]);
    assign rx_pop      = wr_rxpop && !rx_empty;
    assign rx_push     = rx_done && (!rx_full || rx_pop);
    assign overrun_set = rx_done && rx_full && !rx_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wptr <= '0;
            rx_rptr <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + PTR_ONE;
            if (rx_pop)  rx_rptr <= rx_rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr[AW-1:0]] <= rx_shift;
    end

    // ---------------- Registers ----------------
    // Sticky flags: a hardware set in the same cycle as a write-1 clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_en      <= 1'b0;
            rx_en      <= 1'b0;
            baud       <= BAUD_RST;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                tx_en <= data_i[0];
                rx_en <= data_i[1];
            end
            if (wr_baud) baud <= (data_i[15:0] < 16'd4) ? 16'd4 : data_i[15:0];
            rx_overrun <= overrun_set | (rx_overrun & ~(wr_status & data_i[3]));
            frame_err  <= rx_bad | (frame_err & ~(wr_status & data_i[4]));
        end
    end

    always_comb begin
        data_o = '0;
        case (sel)
            3'd0: data_o = {30'd0, rx_en, tx_en};
            3'd1: data_o = {27'd0, frame_err, rx_overrun, !rx_empty, tx_full,
                            (tx_state != IDLE) || !tx_empty};
            3'd2: data_o = {16'd0, baud};
            3'd4: data_o = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rptr[AW-1:0]]};
            default: data_o = '0;
        endcase
    end
endmodule

// File: tb/tb_uart_ctrl.sv
// Randomised bench for uart_ctrl: TX frames are decoded off tx_pin and scored against
// a queue of expected bytes; RX frames are driven serially and read back over the bus.
module tb_uart_ctrl;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        we_i = 1'b0;
    logic        tx_pin;
    logic        rx_pin = 1'b1;

    uart_ctrl #(.DEPTH(DEPTH), .BAUD_RST(16'd434)) dut (
        .clk(clk), .rst(rst), .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
        .we_i(we_i), .tx_pin(tx_pin), .rx_pin(rx_pin)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] tx_exp_q[$];
    logic [7:0] rx_model_q[$];
    int         mon_baud = 434;
    bit         mon_en = 1'b0;
    bit         ovr_m = 1'b0;
    bit         ferr_m = 1'b0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr_i = a;
        data_i = d;
        we_i   = 1'b1;
        @(posedge clk);
        #1;
        we_i   = 1'b0;
        addr_i = '0;
    endtask

    task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr_i = a;
        we_i   = 1'b0;
        #1;
        d = data_o;
    endtask

    // STATUS value implied by the RX model with the transmitter idle.
    function automatic logic [31:0] rx_status_exp();
        return {27'd0, ferr_m, ovr_m, rx_model_q.size() != 0, 2'b00};
    endfunction

    task automatic send_rx(input logic [7:0] b, input bit stop_ok, input int baud);
        @(negedge clk);
        rx_pin = 1'b0;
        repeat (baud) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            repeat (baud) @(negedge clk);
        end
        rx_pin = stop_ok;
        repeat (baud) @(negedge clk);
        rx_pin = 1'b1;
        repeat (2 * baud) @(negedge clk);
    endtask

    // Counts cycles in which STATUS.tx_busy reads 1, bounded.
    task automatic count_busy(output int cnt);
        logic [31:0] d;
        cnt = 0;
        do begin
            read_reg(32'h04, d);
            if (d[0]) cnt++;
        end while (d[0] && cnt < 5000);
    endtask

    // TX monitor: decode each frame mid-bit and score it against the expected queue.
    initial begin
        forever begin
            logic [7:0] got;
            logic       s0, s1;
            int         b;
            @(negedge tx_pin);
            if (mon_en) begin
                b = mon_baud;
                repeat (b / 2) @(posedge clk);
                @(negedge clk);
                s0 = tx_pin;
                for (int i = 0; i < 8; i++) begin
                    repeat (b) @(posedge clk);
                    @(negedge clk);
                    got[i] = tx_pin;
                end
                repeat (b) @(posedge clk);
                @(negedge clk);
                s1 = tx_pin;
                if (tx_exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL tx_unexpected_frame actual=0x%02h required=none", got);
                end else begin
                    check_output("tx_frame", {22'd0, s1, got, s0}, {22'd0, 1'b1, tx_exp_q.pop_front(), 1'b0});
                end
            end
        end
    end

    initial begin
        logic [31:0] d;
        logic [31:0] ra [9];
        logic [31:0] re [9];
        int          cnt, n, b;
        logic [7:0]  byt;

        ra = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h3000_0028};
        re = '{32'd0, 32'd0, 32'd434, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd434};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_output("reset_tx_pin", {31'd0, tx_pin}, 32'd1);
        for (int i = 0; i < 9; i++) begin
            read_reg(ra[i], d);
            check_output($sformatf("reset_read_%0h", ra[i]), d, re[i]);
        end

        write_reg(32'h08, 32'd1);
        read_reg(32'h08, d);
        check_output("baud_clamp", d, 32'd4);

        // Single byte: latency, waveform and duration
        mon_baud = 4;
        mon_en   = 1'b1;
        write_reg(32'h00, 32'd1);
        tx_exp_q.push_back(8'h55);
        write_reg(32'h0C, 32'h55);
        check_output("tx_idle_at_write", {31'd0, tx_pin}, 32'd1);
        @(posedge clk);
        #1;
        check_output("tx_start_latency", {31'd0, tx_pin}, 32'd0);
        count_busy(cnt);
        check_output("tx_frame_cycles", cnt, 32'd40);
        check_output("tx_q_drained_1", tx_exp_q.size(), 32'd0);

        // Fill with tx disabled; the fifth byte must be dropped
        write_reg(32'h00, 32'd0);
        write_reg(32'h0C, 32'h11);
        write_reg(32'h0C, 32'h22);
        write_reg(32'h0C, 32'h33);
        write_reg(32'h0C, 32'h44);
        write_reg(32'h0C, 32'h99);
        read_reg(32'h04, d);
        check_output("tx_full_status", d, 32'h3);
        tx_exp_q.push_back(8'h11);
        tx_exp_q.push_back(8'h22);
        tx_exp_q.push_back(8'h33);
        tx_exp_q.push_back(8'h44);
        write_reg(32'h00, 32'd1);
        @(posedge clk);
        #1;
        count_busy(cnt);
        check_output("tx_burst_cycles", cnt, 32'd160);
        repeat (10) @(negedge clk);
        check_output("tx_q_drained_burst", tx_exp_q.size(), 32'd0);

        // Random bursts: an idle transmitter takes one byte at once, so DEPTH+1 fit
        for (int r = 0; r < 4; r++) begin
            b = $urandom_range(9, 4);
            write_reg(32'h08, b);
            mon_baud = b;
            n = $urandom_range(DEPTH + 2, 1);
            for (int k = 0; k < n; k++) begin
                byt = 8'($urandom);
                if (k < DEPTH + 1) tx_exp_q.push_back(byt);
                write_reg(32'h0C, {24'd0, byt});
            end
            count_busy(cnt);
            repeat (10) @(negedge clk);
            check_output($sformatf("tx_q_drained_rand%0d", r), tx_exp_q.size(), 32'd0);
        end

        // RX basic frame
        write_reg(32'h08, 32'd8);
        write_reg(32'h00, 32'd2);
        send_rx(8'hA3, 1'b1, 8);
        rx_model_q.push_back(8'hA3);
        read_reg(32'h04, d);
        check_output("rx_status_a3", d, rx_status_exp());
        read_reg(32'h10, d);
        check_output("rx_data_a3", d, 32'hA3);
        write_reg(32'h14, 32'd0);
        void'(rx_model_q.pop_front());
        read_reg(32'h04, d);
        check_output("rx_status_popped", d, rx_status_exp());
        read_reg(32'h10, d);
        check_output("rx_data_empty", d, 32'd0);

        // Overrun, sticky clear, framing error
        for (int k = 0; k < 5; k++) begin
            byt = 8'($urandom);
            send_rx(byt, 1'b1, 8);
            if (rx_model_q.size() < DEPTH) rx_model_q.push_back(byt);
            else ovr_m = 1'b1;
        end
        read_reg(32'h04, d);
        check_output("rx_overrun_status", d, rx_status_exp());
        write_reg(32'h04, 32'h08);
        ovr_m = 1'b0;
        read_reg(32'h04, d);
        check_output("rx_overrun_cleared", d, rx_status_exp());
        send_rx(8'h3C, 1'b0, 8);
        ferr_m = 1'b1;
        read_reg(32'h04, d);
        check_output("rx_frame_err", d, rx_status_exp());
        while (rx_model_q.size() != 0) begin
            read_reg(32'h10, d);
            check_output("rx_drain_data", d, {24'd0, rx_model_q.pop_front()});
            write_reg(32'h14, 32'd0);
        end
        read_reg(32'h04, d);
        check_output("rx_drained_status", d, rx_status_exp());
        write_reg(32'h04, 32'h10);
        ferr_m = 1'b0;
        read_reg(32'h04, d);
        check_output("rx_ferr_cleared", d, rx_status_exp());

        // Random RX frames at random divider values
        for (int r = 0; r < 4; r++) begin
            b = $urandom_range(12, 4);
            write_reg(32'h08, b);
            byt = 8'($urandom);
            send_rx(byt, 1'b1, b);
            rx_model_q.push_back(byt);
            read_reg(32'h10, d);
            check_output($sformatf("rx_rand_data%0d", r), d, {24'd0, rx_model_q.pop_front()});
            write_reg(32'h14, 32'd0);
            read_reg(32'h04, d);
            check_output($sformatf("rx_rand_status%0d", r), d, rx_status_exp());
        end

        // Short glitch is rejected, and the receiver still takes a real frame afterwards
        write_reg(32'h08, 32'd8);
        @(negedge clk);
        rx_pin = 1'b0;
        repeat (2) @(negedge clk);
        rx_pin = 1'b1;
        repeat (40) @(negedge clk);
        read_reg(32'h04, d);
        check_output("rx_glitch_status", d, rx_status_exp());
        send_rx(8'h5A, 1'b1, 8);
        read_reg(32'h10, d);
        check_output("rx_after_glitch", d, 32'h5A);
        write_reg(32'h14, 32'd0);

        // Asynchronous reset in the middle of a TX frame
        mon_en = 1'b0;
        write_reg(32'h08, 32'd4);
        write_reg(32'h00, 32'd1);
        write_reg(32'h0C, 32'h00);
        @(posedge clk);
        #1;
        check_output("tx_low_before_reset", {31'd0, tx_pin}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check_output("tx_high_on_reset", {31'd0, tx_pin}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        read_reg(32'h00, d);
        check_output("ctrl_after_reset", d, 32'd0);
        read_reg(32'h04, d);
        check_output("status_after_reset", d, 32'd0);
        read_reg(32'h08, d);
        check_output("baud_after_reset", d, 32'd434);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
